// File: rtl/adxl_spi_pkg.sv
// ADXL362 SPI command bytes, register addresses and burst-master FSM states.
package adxl_spi_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h0A;
  localparam logic [7:0] CMD_READ    = 8'h0B;

  localparam logic [7:0] XDATA_L     = 8'h0E;
  localparam logic [7:0] POWER_CTL   = 8'h2D;
  localparam logic [7:0] PWR_MEASURE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CFG_WR,
    GAP,
    RD_XFER,
    LATCH
  } adxl_state_t;

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: SCK half-period divider, bit counter, MSB-first shift-out, MISO shift-in.
// Transaction of N bits takes 2*CLK_DIV*N cycles from i_start; o_done marks the final SCK fall.
module spi_bit_engine #(
  parameter int CLK_DIV = 4,
  parameter int RX_BITS = 48,
  parameter int CW      = 7
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [CW-1:0]      i_last_idx,
  input  logic [23:0]        i_tx_dat,
  input  logic               i_miso,
  output logic               o_sck,
  output logic               o_mosi,
  output logic               o_done,
  output logic [RX_BITS-1:0] o_rx_dat
);

  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic               r_active;
  logic               r_sck;
  logic [7:0]         r_div;
  logic [CW-1:0]      r_bit_cnt;
  logic [CW-1:0]      r_last_idx;
  logic [23:0]        r_tx;
  logic [RX_BITS-1:0] r_rx;
  logic               w_half_end;
  logic               w_last_bit;

  assign w_half_end = r_active && (r_div == DIV_LAST);
  assign w_last_bit = (r_bit_cnt == r_last_idx);

  assign o_sck    = r_sck;
  assign o_mosi   = r_active ? r_tx[23] : 1'b1;
  assign o_done   = w_half_end && r_sck && w_last_bit;
  assign o_rx_dat = r_rx;

  // MISO is shifted on every rise; after a read only the final RX_BITS (the data phase) remain.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_sck      <= 1'b0;
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_last_idx <= '0;
      r_tx       <= '1;
      r_rx       <= '0;
    end else if (i_start) begin
      r_active   <= 1'b1;
      r_sck      <= 1'b0;
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_last_idx <= i_last_idx;
      r_tx       <= i_tx_dat;
    end else if (w_half_end) begin
      r_div <= '0;
      if (!r_sck) begin
        r_sck <= 1'b1;
        r_rx  <= {r_rx[RX_BITS-2:0], i_miso};
      end else begin
        r_sck <= 1'b0;
        if (w_last_bit) begin
          r_active <= 1'b0;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_ONE;
          r_tx      <= {r_tx[22:0], 1'b1};
        end
      end
    end else if (r_active) begin
      r_div <= r_div + 8'd1;
    end
  end

endmodule

// File: rtl/adxl_spi_burst.sv
// ADXL362 SPI master: optional post-reset config write, then back-to-back BURST_LEN-byte burst reads.
// Define ADXL_SPI_INIT_EN to build the configuration write; otherwise the first transaction is a read.
module adxl_spi_burst
  import adxl_spi_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter int         BURST_LEN = 6,
  parameter logic [7:0] RD_ADDR   = XDATA_L,
  parameter logic [7:0] CFG_ADDR  = POWER_CTL,
  parameter logic [7:0] CFG_DATA  = PWR_MEASURE,
  parameter int         CS_GAP    = 16
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   miso,
  output logic                   spi_sck,
  output logic                   spi_mosi,
  output logic                   spi_cs_n,
  output logic [8*BURST_LEN-1:0] data_out,
  output logic                   data_valid,
  output logic                   init_done,
  output logic                   busy
);

  localparam int            RD_BITS  = 16 + 8 * BURST_LEN;
  localparam int            CW       = $clog2(RD_BITS + 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_BITS - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(23);
  localparam logic [23:0]   RD_TX    = {CMD_READ, RD_ADDR, 8'hFF};
  localparam logic [23:0]   CFG_TX   = {CMD_WRITE, CFG_ADDR, CFG_DATA};
  localparam logic [15:0]   GAP_LAST = 16'(CS_GAP - 1);

  adxl_state_t              r_state;
  adxl_state_t              w_next;
  logic                     r_cs_n;
  logic [15:0]              r_gap_cnt;
  logic [8*BURST_LEN-1:0]   r_data_out;
  logic                     r_data_valid;
  logic                     w_init_done;
  logic                     w_start;
  logic                     w_done;
  logic [23:0]              w_tx;
  logic [CW-1:0]            w_last_idx;
  logic [8*BURST_LEN-1:0]   w_rx_shift;
  logic [8*BURST_LEN-1:0]   w_rx_bytes;

  spi_bit_engine #(
    .CLK_DIV (CLK_DIV),
    .RX_BITS (8 * BURST_LEN),
    .CW      (CW)
  ) u_engine (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_last_idx (w_last_idx),
    .i_tx_dat   (w_tx),
    .i_miso     (miso),
    .o_sck      (spi_sck),
    .o_mosi     (spi_mosi),
    .o_done     (w_done),
    .o_rx_dat   (w_rx_shift)
  );

  // The first byte received ends up in the top of the shift register; byte 0 belongs at the bottom.
  for (genvar k = 0; k < BURST_LEN; k++) begin : g_byte
    assign w_rx_bytes[8*k +: 8] = w_rx_shift[8*(BURST_LEN-1-k) +: 8];
  end

`ifdef ADXL_SPI_INIT_EN
  logic r_init_done;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_done <= 1'b0;
    end else if (r_state == CFG_WR && w_done) begin
      r_init_done <= 1'b1;
    end
  end

  assign w_init_done = r_init_done;
`else
  assign w_init_done = 1'b1;
`endif

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_tx       = RD_TX;
    w_last_idx = RD_LAST;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_start = 1'b1;
          if (w_init_done) begin
            w_next = RD_XFER;
          end else begin
            w_tx       = CFG_TX;
            w_last_idx = WR_LAST;
`ifdef ADXL_SPI_INIT_EN
            w_next     = CFG_WR;
`else
            w_next     = RD_XFER;
`endif
          end
        end
      end
`ifdef ADXL_SPI_INIT_EN
      CFG_WR:  if (w_done) w_next = GAP;
`endif
      RD_XFER: if (w_done) w_next = LATCH;
      LATCH:   w_next = GAP;
      GAP:     if (r_gap_cnt == GAP_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // CS follows the engine's start/done edges so it frames exactly the SCK activity.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cs_n       <= 1'b1;
      r_gap_cnt    <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cs_n <= 1'b0;
      end else if (w_done) begin
        r_cs_n <= 1'b1;
      end
      r_gap_cnt    <= (r_state == GAP) ? r_gap_cnt + 16'd1 : 16'd0;
      r_data_valid <= (r_state == LATCH);
      if (r_state == LATCH) begin
        r_data_out <= w_rx_bytes;
      end
    end
  end

  assign spi_cs_n   = r_cs_n;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign init_done  = w_init_done;
  assign busy       = !r_cs_n || (r_state == LATCH) || (r_state == GAP);

endmodule

// File: tb/tb_adxl_spi_burst.sv
// Bench for adxl_spi_burst: ADXL362 slave model with random burst data and a transaction-level monitor.
module tb_adxl_spi_burst;

  localparam int         CLK_DIV  = 2;
  localparam int         BL       = 6;
  localparam int         CS_GAP   = 16;
  localparam logic [7:0] RD_ADDR  = 8'h0E;
  localparam logic [7:0] CFG_ADDR = 8'h2D;
  localparam logic [7:0] CFG_DATA = 8'h02;
  localparam int         RD_BITS  = 16 + 8 * BL;
  localparam logic [63:0] TAIL_MASK = (64'd1 << (8 * BL)) - 64'd1;
`ifdef ADXL_SPI_INIT_EN
  localparam bit INIT0 = 1'b0;
`else
  localparam bit INIT0 = 1'b1;
`endif

  logic          sclk   = 1'b0;
  logic          rst_n  = 1'b0;
  logic          enable = 1'b0;
  logic          miso   = 1'b0;
  logic          spi_sck, spi_mosi, spi_cs_n;
  logic [8*BL-1:0] data_out;
  logic          data_valid, init_done, busy;

  adxl_spi_burst #(
    .CLK_DIV   (CLK_DIV),
    .BURST_LEN (BL),
    .RD_ADDR   (RD_ADDR),
    .CFG_ADDR  (CFG_ADDR),
    .CFG_DATA  (CFG_DATA),
    .CS_GAP    (CS_GAP)
  ) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .enable     (enable),
    .miso       (miso),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .data_out   (data_out),
    .data_valid (data_valid),
    .init_done  (init_done),
    .busy       (busy)
  );

  always #5 sclk = ~sclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor / reference model state
  int   cyc = 0, n_falls = 0, nvalid = 0, nwrites = 0, rises = 0;
  int   fall_cyc = 0, last_rise = 0, rise_cyc = 0, pend_cyc = 0, busy_lo = 0, min_gap = 0;
  bit   in_xfer = 0, cur_read = 0, m_init = INIT0, pend_valid = 0, busy_chk = 0, have_rise = 0;
  bit   prev_cs = 1, prev_sck = 0;
  logic [127:0] mosi_bits;
  logic [7:0]   rbytes [BL];
  logic [63:0]  m_exp = '0, m_last = '0;

  function automatic logic slave_bit(input int n);
    int j;
    logic [7:0] b;
    if (!cur_read || n < 16 || n >= RD_BITS) return 1'b0;
    j = n - 16;
    b = rbytes[j / 8];
    return b[7 - (j % 8)];
  endfunction

  always @(negedge sclk) begin
    int nb;
    logic [127:0] sh;
    logic [7:0] b0, b1, b2;
    cyc++;
    if (!rst_n) begin
      in_xfer = 0; pend_valid = 0; busy_chk = 0; have_rise = 0;
      m_init = INIT0; m_last = '0; miso = 1'b0;
    end else begin
      if (prev_cs && !spi_cs_n) begin
        n_falls++;
        if (have_rise) check_eq("cs_gap_min", 64'((cyc - rise_cyc) >= min_gap), 64'd1);
        check_eq("busy_xfer", busy, 1);
        check_eq("mosi_bit7_at_cs", spi_mosi, 0);
        check_eq("hold_data", data_out, m_last);
        check_eq("init_done_state", init_done, m_init);
        in_xfer = 1; cur_read = m_init; fall_cyc = cyc; rises = 0; mosi_bits = '0;
        for (int k = 0; k < BL; k++) rbytes[k] = 8'($urandom);
      end
      if (in_xfer && !spi_cs_n && !prev_sck && spi_sck) begin
        rises++;
        mosi_bits = {mosi_bits[126:0], spi_mosi};
        if (rises == 1) check_eq("first_rise", cyc - fall_cyc, CLK_DIV);
        last_rise = cyc;
      end
      if (in_xfer && spi_cs_n) begin
        nb = cur_read ? RD_BITS : 24;
        check_eq("cs_low_len", cyc - fall_cyc, 2 * CLK_DIV * nb);
        check_eq("sck_rises", rises, nb);
        check_eq("cs_after_last_rise", cyc - last_rise, CLK_DIV);
        check_eq("sck_low_at_cs_rise", spi_sck, 0);
        sh = mosi_bits >> (nb - 8);  b0 = sh[7:0];
        sh = mosi_bits >> (nb - 16); b1 = sh[7:0];
        sh = mosi_bits >> (nb - 24); b2 = sh[7:0];
        if (cur_read) begin
          check_eq("rd_cmd", b0, 8'h0B);
          check_eq("rd_addr", b1, RD_ADDR);
          check_eq("rd_mosi_high", mosi_bits[63:0] & TAIL_MASK, TAIL_MASK);
          m_exp = '0;
          for (int k = 0; k < BL; k++) m_exp = m_exp | (64'(rbytes[k]) << (8 * k));
          pend_valid = 1; pend_cyc = cyc + 1;
          min_gap = CS_GAP + 2; busy_lo = cyc + CS_GAP + 1;
        end else begin
          check_eq("wr_cmd", b0, 8'h0A);
          check_eq("wr_addr", b1, CFG_ADDR);
          check_eq("wr_data", b2, CFG_DATA);
          check_eq("init_done_set", init_done, 1);
          m_init = 1; nwrites++;
          min_gap = CS_GAP + 1; busy_lo = cyc + CS_GAP;
        end
        busy_chk = 1; have_rise = 1; rise_cyc = cyc; in_xfer = 0;
      end
      if (in_xfer) miso = slave_bit(rises);
      if (data_valid) begin
        nvalid++;
        if (pend_valid) begin
          check_eq("dv_cycle", cyc, pend_cyc);
          check_eq("data_out", data_out, m_exp);
          m_last = m_exp;
          pend_valid = 0;
        end else begin
          check_eq("dv_spurious", data_valid, 0);
        end
      end else if (pend_valid && cyc > pend_cyc) begin
        check_eq("dv_missing", data_valid, 1);
        pend_valid = 0;
      end
      if (busy_chk) begin
        if (cyc == busy_lo - 1) check_eq("busy_gap", busy, 1);
        if (cyc == busy_lo) begin
          check_eq("busy_idle", busy, 0);
          busy_chk = 0;
        end
      end
    end
    prev_cs  = spi_cs_n;
    prev_sck = spi_sck;
  end

  task automatic wait_nvalid(input int target, input int limit, input string tag);
    for (int i = 0; i < limit && nvalid < target; i++) begin
      @(negedge sclk); #1;
    end
    check_eq(tag, 64'(nvalid >= target), 64'd1);
  endtask

  task automatic wait_read_bit(input int bitn, input int limit, input string tag);
    for (int i = 0; i < limit && !(in_xfer && cur_read && rises >= bitn); i++) begin
      @(negedge sclk); #1;
    end
    check_eq(tag, 64'(in_xfer && cur_read && rises >= bitn), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, f0, w0, t1, t2;
    rst_n = 1'b0; enable = 1'b0;
    repeat (10) @(negedge sclk);
    #1 rst_n = 1'b1;
    @(negedge sclk); #1;
    check_eq("rst_cs_n", spi_cs_n, 1);
    check_eq("rst_sck", spi_sck, 0);
    check_eq("rst_mosi", spi_mosi, 1);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_init_done", init_done, INIT0);
    repeat (1000) @(negedge sclk); #1;
    check_eq("idle_no_cs", n_falls, 0);
    check_eq("idle_busy", busy, 0);

    enable = 1'b1;
    wait_nvalid(1, 2000, "first_burst");
    v0 = nvalid;
    wait_nvalid(v0 + 1, 1000, "burst_a");
    t1 = cyc;
    wait_nvalid(v0 + 2, 1000, "burst_b");
    t2 = cyc;
    check_eq("bb_period", t2 - t1, 2 * CLK_DIV * RD_BITS + 1 + CS_GAP + 1);

    wait_read_bit(20, 2000, "reach_bit20");
    enable = 1'b0;
    v0 = nvalid; f0 = n_falls;
    repeat (1500) @(negedge sclk); #1;
    check_eq("drop_one_valid", nvalid - v0, 1);
    check_eq("drop_no_cs", n_falls - f0, 0);
    check_eq("drop_parked_cs", spi_cs_n, 1);
    check_eq("drop_parked_busy", busy, 0);

    enable = 1'b1;
    wait_read_bit(10, 2000, "reach_bit10");
    w0 = nwrites; v0 = nvalid;
    rst_n = 1'b0;
    #1;
    check_eq("arst_cs_n", spi_cs_n, 1);
    check_eq("arst_sck", spi_sck, 0);
    check_eq("arst_mosi", spi_mosi, 1);
    check_eq("arst_data_out", data_out, 0);
    check_eq("arst_valid", data_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_init_done", init_done, INIT0);
    repeat (5) @(negedge sclk);
    #1 rst_n = 1'b1;
    wait_nvalid(v0 + 1, 3000, "post_rst_burst");
    check_eq("cfg_rewrite", nwrites - w0, INIT0 ? 0 : 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adxl_spi_burst.md
# adxl_spi_burst

Parametrised SPI master for the ADXL362 accelerometer, succeeding the fixed single-byte reader. After reset it optionally writes one configuration register (default POWER_CTL = measure mode). It then polls a block of BURST_LEN consecutive registers with the burst-read command. Each completed burst is presented as one parallel word with a valid strobe to the downstream display/processing logic.

## Interface
- CLK_DIV, 4: sclk cycles per SCK half-period; legal range 2..255.
- BURST_LEN, 6: data bytes per read burst; legal range 1..8.
- RD_ADDR, 8'h0E: first register address of the read burst.
- CFG_ADDR, 8'h2D: configuration register address.
- CFG_DATA, 8'h02: configuration value.
- CS_GAP, 16: minimum sclk cycles CS stays high between transactions; minimum 2.
- sclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; high enables back-to-back polling.
- miso  in  1  serial data from the sensor.
- spi_sck  out  1  SPI clock; mode 0, idle low.
- spi_mosi  out  1  serial data to the sensor; idle high.
- spi_cs_n  out  1  chip select, active low.
- data_out  out  8*BURST_LEN  last burst; byte k sits in [8k+7:8k], where byte 0 is RD_ADDR.
- data_valid  out  1  one-cycle pulse when data_out updates.
- init_done  out  1  high once the configuration write has completed.
- busy  out  1  high while CS is low or the CS_GAP count is running.

## Operation
- The block is clocked only by sclk. SCK is generated from a half-period counter. No logic runs on SCK edges.
- FSM states: IDLE, CFG_WR, GAP, RD_XFER, LATCH.
- IDLE: CS high, SCK low, MOSI high. Goes to CFG_WR when init_done=0, otherwise to RD_XFER, in both cases only while enable=1.
- CFG_WR: sends 24 bits MSB-first: 8'h0A, CFG_ADDR, CFG_DATA. At the end: init_done<=1, then GAP.
- RD_XFER: sends 8'h0B and RD_ADDR (16 bits), then clocks 8*BURST_LEN bits in from miso while MOSI is held high. Received bytes are assembled into a shadow register, byte 0 first received, MSB-first within each byte. Goes to LATCH at the end.
- LATCH: data_out<=shadow, data_valid=1 for exactly one cycle, then GAP.
- GAP: CS high for CS_GAP cycles, then IDLE.
- enable falling mid-transaction: the current transaction completes fully, including LATCH and GAP, then the block parks in IDLE.
- data_out holds its value between bursts. A partial burst never reaches data_out.
- A bit counter wider than 8*BURST_LEN+16 is required. The counter does not wrap within a transaction.

## Timing
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=1, data_out=0, data_valid=0, init_done=0, busy=0, state IDLE. Reset assertion forces these values immediately, including mid-transaction. The configuration write repeats after reset release.
- CS falls on the cycle the FSM leaves IDLE, and MOSI bit 7 is valid in that same cycle.
- First SCK rise occurs CLK_DIV cycles after CS falls. SCK period is 2*CLK_DIV cycles.
- MOSI changes on the sclk edge that drives SCK low. miso is sampled on the sclk edge that drives SCK high.
- CS rises CLK_DIV cycles after the last SCK rise, leaving SCK low.
- CS low time = 2*CLK_DIV*NBITS cycles, where NBITS is 24 for the write and 16+8*BURST_LEN for the read.
- data_valid pulses in the cycle after CS rises at the end of a read.
- Back-to-back period while enable is high = read CS-low time + 1 (LATCH) + CS_GAP + 1 (IDLE) cycles.

## Configuration
- ADXL_SPI_INIT_EN defined: the CFG_WR state and init_done logic are present, as described above.
- ADXL_SPI_INIT_EN undefined: CFG_WR is not built, init_done is tied to 1, and the first transaction after reset is a read. CFG_ADDR and CFG_DATA are ignored.

## Structure
- Package adxl_spi_pkg holds:
  - the command constants CMD_WRITE=8'h0A, CMD_READ=8'h0B;
  - the ADXL362 register addresses (XDATA_L=8'h0E, POWER_CTL=8'h2D);
  - the FSM state enum.
- Sub-module spi_bit_engine owns the SCK half-period counter, the bit counter, the MOSI shift-out and the MISO shift-in. It is started by a pulse with a bit count and signals done. The FSM and output registers stay in adxl_spi_burst.

## Test plan
- Reset held for 10 cycles, then released with enable=0 → all outputs at their reset values, and no CS activity for 1000 cycles.
- CLK_DIV=2, macro defined, enable=1 → MOSI sequence 0x0A, 0x2D, 0x02 sampled over 24 SCK rises; CS low for 96 cycles; init_done rises; CS high for ≥16 cycles.
- BURST_LEN=6, slave model returns 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 → MOSI sends 0x0B, 0x0E; data_out=48'h665544332211; exactly one data_valid pulse, one cycle after CS rises.
- enable dropped at bit 20 of a read → burst completes, data_valid pulses once, then no further CS fall until enable rises again.
- rst_n asserted at bit 10 of a read → CS high and SCK low in the same cycle; data_out=0; after release, the configuration write is sent again.
- Macro undefined → the first CS-low transaction carries 0x0B, and init_done=1 from reset release.
